dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer for the MEM stage's data-memory access. It takes the load/store controls and operands held in the EX/MEM pipeline register and runs a req/ack transaction to the data memory. It generates byte strobes and lane-replicated write data, and extracts and extends load data. It freezes the pipeline with `mem_stall` until the access completes, and flags misaligned accesses and memory timeouts.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ waiting for `dm_ack`. 0 disables the timeout.
- `clk` in, 1 bit: clock; all state updates on the rising edge.
- `rst` in, 1 bit: reset, asynchronous, active-low.
- `MEM_MemRead` in, 1 bit: load in MEM stage.
- `MEM_MemWrite` in, 1 bit: store in MEM stage; has priority if both are set.
- `MEM_funct3` in, 3 bits: access size and sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `MEM_alu_result` in, 32 bits: byte address.
- `MEM_rs2_data` in, 32 bits: store data.
- `dm_req` out, 1 bit: request, registered, held until ack.
- `dm_we` out, 1 bit: 1 = write.
- `dm_addr` out, 32 bits: word address; bits [1:0] are always 0.
- `dm_wstrb` out, 4 bits: byte write enables; 0 for reads.
- `dm_wdata` out, 32 bits: lane-replicated store data.
- `dm_ack` in, 1 bit: access complete; valid only while `dm_req` is 1.
- `dm_rdata` in, 32 bits: read word, valid with `dm_ack`.
- `mem_stall` out, 1 bit: hold the IF..EX/MEM registers.
- `MEM_load_data` out, 32 bits: extended load result.
- `misalign_err` out, 1 bit: 1-cycle pulse on a misaligned or illegal-size access.
- `bus_err` out, 1 bit: 1-cycle pulse on a timeout.

## Operation
- Access classification:
  - op = `MEM_MemRead` | `MEM_MemWrite`; we = `MEM_MemWrite`.
  - Misaligned: W with addr[1:0]≠0; H/HU with addr[0]=1; funct3 ∈ {3,6,7}.
- FSM states: IDLE, REQ, DONE.
- IDLE, no op: `mem_stall`=0, stay.
- IDLE, op misaligned:
  - no request issued; `misalign_err`=1 this cycle; `mem_stall`=0.
  - `MEM_load_data`=0; store suppressed; stay IDLE.
- IDLE, op aligned:
  - `mem_stall`=1 (combinational).
  - Register `dm_addr`={addr[31:2],2'b00}, `dm_we`, `dm_wstrb`, `dm_wdata`, and lane info (addr[1:0], funct3).
  - Set `dm_req`; go to REQ; clear timeout counter.
- REQ: `mem_stall`=1; counter increments each cycle.
  - `dm_ack`=1: capture extended `dm_rdata` into the load register; drop `dm_req`; go to DONE.
  - Counter reaches TIMEOUT (TIMEOUT>0) with no ack: drop `dm_req`; pulse `bus_err`; load register = 0; go to DONE.
  - Ack in the same cycle as the timeout: ack wins, no `bus_err`.
- DONE:
  - `mem_stall`=0; `MEM_load_data` = load register; go to IDLE.
  - The pipeline advances at the end of this cycle; no new access is started in DONE even though the MEM inputs still show the old op.
- Store strobes and data:
  - SB: strobe = 4'b0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: strobe = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: strobe = 4'b1111; wdata = rs2.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- `MEM_load_data` is 0 outside DONE.

## Timing
- Reset (`rst`=0, asynchronous):
  - state IDLE; `dm_req`, `dm_we`, `dm_wstrb`, `dm_addr`, `dm_wdata`, `MEM_load_data`, `misalign_err`, `bus_err`, counter all 0.
  - `mem_stall` is 0 (IDLE, ops masked during reset).
- Reset mid-REQ: `dm_req` drops immediately and the in-flight ack is ignored.
- Op enters MEM at cycle 0: `dm_req` is high from cycle 1; ack at cycle k≥1; DONE at k+1; next instruction enters MEM at k+2.
  - Minimum memory-op occupancy is 3 cycles; non-memory instructions take 1.
- `dm_req`, `dm_addr`, `dm_we`, `dm_wstrb` and `dm_wdata` are stable from request until the cycle after ack.
- Back-to-back memory ops: IDLE→REQ→DONE→IDLE→REQ; one IDLE cycle between them is required.
- Timeout with TIMEOUT=N: `bus_err` pulses at the N-th REQ cycle without ack; DONE follows.

## Test plan
- LW addr 0x100, memory word 0x8000_00FF, ack 1 cycle after req:
  - `dm_addr`=0x100, `dm_wstrb`=0.
  - `mem_stall` high for 2 cycles; DONE gives `MEM_load_data`=0x8000_00FF.
- LB addr 0x103 and LBU addr 0x103, word 0x80AB_CDEF: LB → 0xFFFF_FF80; LBU → 0x0000_0080.
- SH addr 0x202, rs2=0x1234_5678, ack after 3 wait cycles:
  - `dm_addr`=0x200, `dm_wstrb`=4'b1100, `dm_wdata`=0x5678_5678.
  - Outputs stable through the wait; `mem_stall` high for 4 cycles.
- LW addr 0x101: `misalign_err` pulses once; `dm_req` stays 0; `mem_stall` stays 0. Repeat with SH addr 0x301: same result, no write.
- TIMEOUT=4, LW with no ack: `dm_req` held for 4 cycles then drops; `bus_err` pulses; DONE gives `MEM_load_data`=0. Variant with ack in cycle 4: no `bus_err`.
- Assert `rst` low in the second REQ cycle: all outputs are 0 immediately; after release the FSM is IDLE and a new SW completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Data-memory request/acknowledge bus between the MEM-stage access sequencer
// and the data memory.
//   dm_req   : request, held until dm_ack
//   dm_we    : 1 = write, 0 = read
//   dm_addr  : word address (bits [1:0] always 0)
//   dm_wstrb : byte write enables (0 for reads)
//   dm_wdata : lane-replicated store data
//   dm_ack   : access complete, meaningful only while dm_req is 1
//   dm_rdata : read word, valid together with dm_ack
// master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access sequencer. Takes the load/store controls held in
// the EX/MEM register, runs one req/ack transaction on the data-memory bus,
// builds byte strobes and lane-replicated store data, extracts and extends
// load data, and holds the pipeline with mem_stall until the access ends.
// Misaligned / illegal-size accesses and bus timeouts are flagged.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   MEM_MemRead    : load in MEM
//   MEM_MemWrite   : store in MEM (wins over MEM_MemRead)
//   MEM_funct3     : 0 B, 1 H, 2 W, 4 BU, 5 HU
//   MEM_alu_result : byte address
//   MEM_rs2_data   : store data
//   dm             : data-memory bus (master side)
//   mem_stall      : hold IF..EX/MEM registers
//   MEM_load_data  : extended load result, non-zero only in DONE
//   misalign_err   : 1-cycle pulse on misaligned / illegal-size access
//   bus_err        : 1-cycle pulse on a request timeout
// Parameter TIMEOUT: max REQ cycles without dm_ack (0 disables the timeout).
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MEM_MemRead,
    input  logic                       MEM_MemWrite,
    input  logic [2:0]                 MEM_funct3,
    input  logic [31:0]                MEM_alu_result,
    input  logic [31:0]                MEM_rs2_data,
    dmem_access_ctrl_if.master         dm,
    output logic                       mem_stall,
    output logic [31:0]                MEM_load_data,
    output logic                       misalign_err,
    output logic                       bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value in the last REQ cycle allowed before a timeout fires.
    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic        TMO_ON   = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    state_t      state_r;
    logic [31:0] cnt_r;
    logic [1:0]  lane_r;
    logic [2:0]  f3_r;

    logic        op_s;
    logic        misalign_s;
    logic        timeout_hit_s;

    // Size 0/4 = byte, 1/5 = half, 2 = word; 3, 6, 7 are illegal sizes.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic r;
        case (f3)
            3'd0, 3'd4: r = 1'b0;
            3'd1, 3'd5: r = a[0];
            3'd2:       r = (a != 2'b00);
            default:    r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] r;
        case (f3[1:0])
            2'd0:    r = 4'b0001 << a;
            2'd1:    r = a[1] ? 4'b1100 : 4'b0011;
            2'd2:    r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // The memory picks the lanes with dm_wstrb, so the data is simply replicated.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            2'd2:    r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = w;
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Access classification and the combinational stall / error flags; all
    // gated by rst so nothing is visible while reset is asserted.
    always_comb begin
        op_s          = MEM_MemRead | MEM_MemWrite;
        misalign_s    = is_misaligned(MEM_funct3, MEM_alu_result[1:0]);
        timeout_hit_s = TMO_ON & (cnt_r == TMO_LAST);
        mem_stall     = 1'b0;
        misalign_err  = 1'b0;
        bus_err       = 1'b0;
        if (rst) begin
            case (state_r)
                ST_IDLE: begin
                    mem_stall    = op_s & ~misalign_s;
                    misalign_err = op_s & misalign_s;
                end
                ST_REQ: begin
                    mem_stall = 1'b1;
                    // An ack arriving in the timeout cycle takes precedence.
                    bus_err   = ~dm.dm_ack & timeout_hit_s;
                end
                default: begin
                    mem_stall = 1'b0;
                end
            endcase
        end else begin
            mem_stall = 1'b0;
        end
    end

    // Access FSM with registered bus outputs and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 32'd0;
            lane_r        <= 2'd0;
            f3_r          <= 3'd0;
            dm.dm_req     <= 1'b0;
            dm.dm_we      <= 1'b0;
            dm.dm_addr    <= 32'd0;
            dm.dm_wstrb   <= 4'd0;
            dm.dm_wdata   <= 32'd0;
            MEM_load_data <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    MEM_load_data <= 32'd0;
                    // Misaligned ops are dropped here: no request, no write.
                    if (op_s && !misalign_s) begin
                        dm.dm_req   <= 1'b1;
                        dm.dm_we    <= MEM_MemWrite;
                        dm.dm_addr  <= {MEM_alu_result[31:2], 2'b00};
                        dm.dm_wstrb <= MEM_MemWrite ? store_strb(MEM_funct3, MEM_alu_result[1:0])
                                                    : 4'd0;
                        dm.dm_wdata <= MEM_MemWrite ? store_data(MEM_funct3, MEM_rs2_data)
                                                    : 32'd0;
                        lane_r      <= MEM_alu_result[1:0];
                        f3_r        <= MEM_funct3;
                        cnt_r       <= 32'd0;
                        state_r     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + 32'd1;
                    if (dm.dm_ack) begin
                        MEM_load_data <= load_extend(f3_r, lane_r, dm.dm_rdata);
                        dm.dm_req     <= 1'b0;
                        state_r       <= ST_DONE;
                    end else if (timeout_hit_s) begin
                        MEM_load_data <= 32'd0;
                        dm.dm_req     <= 1'b0;
                        state_r       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The old op is still on the MEM inputs; do not restart it.
                    MEM_load_data <= 32'd0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    dm.dm_req     <= 1'b0;
                    MEM_load_data <= 32'd0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        bus_err;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_MemRead    (mem_read),
        .MEM_MemWrite   (mem_write),
        .MEM_funct3     (funct3),
        .MEM_alu_result (alu),
        .MEM_rs2_data   (rs2),
        .dm             (bus),
        .mem_stall      (mem_stall),
        .MEM_load_data  (load_data),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int mis_cnt = 0;
    int berr_cnt = 0;

    bit          chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_mis, exp_berr, exp_bus, exp_we;
    logic [31:0] exp_load, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    function automatic int nbytes_of(input logic [2:0] f3);
        if (f3 == 3'd2) return 4;
        else if (f3 == 3'd1 || f3 == 3'd5) return 2;
        else return 1;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        return (int'(a[1:0]) % nbytes_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        logic [3:0] mask;
        nb   = nbytes_of(f3);
        mask = 4'((1 << nb) - 1);
        return 4'(mask << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int nb;
        logic [31:0] r;
        nb = nbytes_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        int nb;
        int width;
        logic [31:0] s, mask, v;
        nb = nbytes_of(f3);
        if (nb == 4) return word;
        width = 8 * nb;
        s     = word >> (8 * int'(a[1:0]));
        mask  = (32'd1 << width) - 32'd1;
        v     = s & mask;
        if (f3 < 3'd4 && v[width-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("dm_req", 32'(bus.dm_req), 32'(exp_req));
                check("mem_stall", 32'(mem_stall), 32'(exp_stall));
                check("misalign_err", 32'(misalign_err), 32'(exp_mis));
                check("bus_err", 32'(bus_err), 32'(exp_berr));
                check("MEM_load_data", load_data, exp_load);
                if (exp_bus) begin
                    check("dm_addr", bus.dm_addr, exp_addr);
                    check("dm_we", 32'(bus.dm_we), 32'(exp_we));
                    check("dm_wstrb", 32'(bus.dm_wstrb), 32'(exp_strb));
                    if (exp_we) check("dm_wdata", bus.dm_wdata, exp_wdata);
                end
                if (mem_stall) stall_cnt++;
                if (misalign_err) mis_cnt++;
                if (bus_err) berr_cnt++;
            end
        end
    end

    task automatic set_idle_exp();
        exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
        exp_bus = 1'b0; exp_load = 32'd0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        bus.dm_ack = 1'b0;
        set_idle_exp();
    endtask

    // One instruction in MEM; ack_at = REQ cycle number carrying dm_ack (0 = never).
    // The pin_* literals are hand-computed and pin the model.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] word,
                          input int ack_at, input logic [31:0] pin_load, input int pin_stall,
                          input int pin_mis, input int pin_berr);
        bit mis;
        bit acked;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; alu = a; rs2 = d;
        bus.dm_ack = 1'b0;
        stall_cnt = 0; mis_cnt = 0; berr_cnt = 0;
        mis = m_misaligned(f3, a);
        set_idle_exp();
        exp_mis   = mis;
        exp_stall = !mis;
        exp_addr  = {a[31:2], 2'b00};
        exp_we    = wr;
        exp_strb  = wr ? m_strb(f3, a) : 4'd0;
        exp_wdata = m_wdata(f3, d);
        acked = 1'b0;
        if (mis) begin
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            set_idle_exp();
            check("pin_misalign_pulses", 32'(mis_cnt), 32'(pin_mis));
            check("pin_stall_cycles", 32'(stall_cnt), 32'(pin_stall));
        end else begin
            for (int i = 1; i <= 64; i++) begin
                @(posedge clk); #1;
                exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; exp_bus = 1'b1;
                if (i == ack_at) begin
                    bus.dm_ack = 1'b1; bus.dm_rdata = word; acked = 1'b1;
                end else begin
                    bus.dm_ack = 1'b0; bus.dm_rdata = 32'hDEAD_BEEF;
                end
                exp_berr = !acked && (i == TMO);
                if (acked || i == TMO) break;
            end
            @(posedge clk); #1;
            bus.dm_ack = 1'b0;
            exp_req = 1'b0; exp_stall = 1'b0; exp_berr = 1'b0;
            exp_load = acked ? m_load(f3, a, word) : 32'd0;
            @(negedge clk); #1;
            check("pin_load_data", load_data, pin_load);
            check("pin_stall_cycles", 32'(stall_cnt), 32'(pin_stall));
            check("pin_bus_err_pulses", 32'(berr_cnt), 32'(pin_berr));
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; alu = 32'd0; rs2 = 32'd0;
        bus.dm_ack = 1'b0; bus.dm_rdata = 32'd0;
        set_idle_exp();
        exp_addr = 32'd0; exp_we = 1'b0; exp_strb = 4'd0; exp_wdata = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dm_req", 32'(bus.dm_req), 32'd0);
        check("rst_dm_addr", bus.dm_addr, 32'd0);
        check("rst_dm_wstrb", 32'(bus.dm_wstrb), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // rd wr f3 addr rs2 word ack_at pin_load stall mis berr
        run_op(1, 0, 3'd2, 32'h0000_0100, 32'd0, 32'h8000_00FF, 1, 32'h8000_00FF, 2, 0, 0);
        run_op(1, 0, 3'd0, 32'h0000_0103, 32'd0, 32'h80AB_CDEF, 1, 32'hFFFF_FF80, 2, 0, 0);
        run_op(1, 0, 3'd4, 32'h0000_0103, 32'd0, 32'h80AB_CDEF, 1, 32'h0000_0080, 2, 0, 0);
        run_op(0, 1, 3'd1, 32'h0000_0202, 32'h1234_5678, 32'd0, 3, 32'd0, 4, 0, 0);
        idle_cycle();
        #1;
        check("pin_sh_addr", bus.dm_addr, 32'h0000_0200);
        check("pin_sh_wstrb", 32'(bus.dm_wstrb), 32'h0000_000C);
        check("pin_sh_wdata", bus.dm_wdata, 32'h5678_5678);
        run_op(1, 0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 1, 32'd0, 0, 1, 0);
        run_op(0, 1, 3'd1, 32'h0000_0301, 32'hAAAA_5555, 32'd0, 1, 32'd0, 0, 1, 0);
        run_op(1, 0, 3'd3, 32'h0000_0100, 32'd0, 32'd0, 1, 32'd0, 0, 1, 0);
        run_op(1, 0, 3'd2, 32'h0000_0104, 32'd0, 32'h1111_1111, 0, 32'd0, 5, 0, 1);
        run_op(1, 0, 3'd2, 32'h0000_0108, 32'd0, 32'h1357_9BDF, 4, 32'h1357_9BDF, 5, 0, 0);
        run_op(1, 0, 3'd1, 32'h0000_0106, 32'd0, 32'h8001_7FFF, 2, 32'hFFFF_8001, 3, 0, 0);
        run_op(1, 0, 3'd5, 32'h0000_0106, 32'd0, 32'h8001_7FFF, 2, 32'h0000_8001, 3, 0, 0);
        run_op(0, 1, 3'd0, 32'h0000_0101, 32'h0000_00AB, 32'd0, 1, 32'd0, 2, 0, 0);
        idle_cycle();
        #1;
        check("pin_sb_wstrb", 32'(bus.dm_wstrb), 32'h0000_0002);
        check("pin_sb_wdata", bus.dm_wdata, 32'hABAB_ABAB);

        // reset in the second REQ cycle, with an ack in flight
        chk_en = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; alu = 32'h0000_0400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'h1111_2222;
        #1 rst = 1'b0;
        #1;
        check("mid_rst_dm_req", 32'(bus.dm_req), 32'd0);
        check("mid_rst_dm_addr", bus.dm_addr, 32'd0);
        check("mid_rst_mem_stall", 32'(mem_stall), 32'd0);
        check("mid_rst_load_data", load_data, 32'd0);
        check("mid_rst_errs", 32'({misalign_err, bus_err}), 32'd0);
        mem_read = 1'b0;
        @(posedge clk); #1;
        check("in_rst_load_data", load_data, 32'd0);
        bus.dm_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("post_rst_idle_stall", 32'(mem_stall), 32'd0);
        check("post_rst_idle_req", 32'(bus.dm_req), 32'd0);
        set_idle_exp();
        chk_en = 1'b1;
        run_op(0, 1, 3'd2, 32'h0000_0500, 32'hCAFE_F00D, 32'd0, 2, 32'd0, 3, 0, 0);
        idle_cycle();
        #1;
        check("pin_sw_wstrb", 32'(bus.dm_wstrb), 32'h0000_000F);
        check("pin_sw_wdata", bus.dm_wdata, 32'hCAFE_F00D);
        idle_cycle();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
